// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream_mux_rr channel multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // A channel index needs at least one bit, even when N is 1 or 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake and data bundle between N_CH producer channels, the mux and its sink.
interface stream_mux_rr_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8
);
  import mux_pkg::*;

  localparam int SEL_W = clog2_min1(N_CH);

  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_ready;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and the wrapping search for the first requester.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr;
  int               idx;

  // Walk offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_idx   = IDX_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready mux with manual or round-robin channel selection and a registered output stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);

  localparam int SEL_W = clog2_min1(N_CH);

  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load;
  logic             advance;

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign load    = !bus.out_valid || bus.out_ready;
  assign advance = (bus.mode == MODE_RR) && load && grant_valid;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.in_valid),
    .advance   (advance),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Manual mode with sel beyond the last channel grants nothing.
  always_comb begin
    grant       = rr_idx;
    grant_valid = rr_valid;
    if (bus.mode == MODE_MANUAL) begin
      grant       = bus.sel;
      grant_valid = (int'(bus.sel) < N_CH) && bus.in_valid[bus.sel];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && grant_valid) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (load) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      bus.out_valid <= grant_valid;
      if (grant_valid) begin
        bus.out_data <= bus.in_data[int'(grant)*DATA_W +: DATA_W];
        bus.out_ch   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: scoreboard of expected output beats plus direct handshake checks.
module tb_stream_mux_rr;
  import mux_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] ch;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t exp_beat;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(8), .DATA_W(8)) bus  ();
  stream_mux_rr_if #(.N_CH(5), .DATA_W(8)) bus5 ();

  stream_mux_rr #(.N_CH(8), .DATA_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  stream_mux_rr #(.N_CH(5), .DATA_W(8)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] c);
    beat_t b;
    b.data = d;
    b.ch   = c;
    sb.push_back(b);
  endtask

  // Channel k carries 8'h30 + k unless a test overrides it.
  task automatic fill_data();
    for (int k = 0; k < 8; k++) bus.in_data[k*8 +: 8] = 8'h30 + 8'(k);
    for (int k = 0; k < 5; k++) bus5.in_data[k*8 +: 8] = 8'h30 + 8'(k);
  endtask

  // Monitor: every beat the sink accepts must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch %0d data %0h expected no beat", bus.out_ch, bus.out_data);
      end else begin
        exp_beat = sb.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(exp_beat.data));
        check("sb_ch",   32'(bus.out_ch),   32'(exp_beat.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.mode      = MODE_MANUAL;
    bus.sel       = '0;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    bus5.mode      = MODE_MANUAL;
    bus5.sel       = '0;
    bus5.in_valid  = '0;
    bus5.out_ready = 1'b1;
    fill_data();
    #3;
    check("reset_in_ready",  32'(bus.in_ready),  32'h0);
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_out_ch",    32'(bus.out_ch),    32'h0);
    check("reset_out_data",  32'(bus.out_data),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = '0;

    // Manual select of channel 3.
    bus.sel = 3'd3;
    bus.in_data[3*8 +: 8] = 8'hA5;
    bus.in_valid = '1;
    #1 check("manual_in_ready", 32'(bus.in_ready), 32'h08);
    push(8'hA5, 3'd3);
    @(posedge clk);
    #1 bus.in_valid = '0;
    fill_data();
    check("manual_out_ch",   32'(bus.out_ch),   32'd3);
    check("manual_out_data", 32'(bus.out_data), 32'hA5);
    @(posedge clk);
    #1 check("manual_drain_valid", 32'(bus.out_valid), 32'h0);

    // Round-robin with every channel valid: 0..7 then 0 again.
    bus.mode     = MODE_RR;
    bus.in_valid = '1;
    #1 check("rr_first_ready", 32'(bus.in_ready), 32'h01);
    for (int i = 0; i < 9; i++) push(8'h30 + 8'(i % 8), 3'(i % 8));
    repeat (9) @(posedge clk);
    #1 bus.in_valid = '0;

    // Empty inputs: output drains, pointer stays at 1.
    @(posedge clk);
    #1 check("empty_valid_drop", 32'(bus.out_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1 check("empty_valid_stays", 32'(bus.out_valid), 32'h0);
    bus.in_valid = '1;
    #1 check("empty_ptr_held", 32'(bus.in_ready), 32'h02);
    push(8'h31, 3'd1);
    @(posedge clk);

    // Skip and wrap from pointer 2 with only channels 7 and 1 requesting.
    #1 bus.in_valid = 8'b1000_0010;
    #1 check("wrap_grant_7a", 32'(bus.in_ready), 32'h80);
    push(8'h37, 3'd7);
    @(posedge clk);
    #1 check("wrap_grant_1", 32'(bus.in_ready), 32'h02);
    push(8'h31, 3'd1);
    @(posedge clk);
    #1 check("wrap_grant_7b", 32'(bus.in_ready), 32'h80);
    push(8'h37, 3'd7);
    @(posedge clk);
    #1 bus.in_valid = '0;
    @(posedge clk);

    // Backpressure: held beat stays stable and no channel is granted.
    #1 bus.out_ready = 1'b0;
    bus.in_valid = '1;
    #1 check("bp_first_ready", 32'(bus.in_ready), 32'h01);
    push(8'h30, 3'd0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(bus.in_ready),  32'h0);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      check("bp_out_data",  32'(bus.out_data),  32'h30);
      check("bp_out_ch",    32'(bus.out_ch),    32'h0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.in_ready), 32'h02);
    push(8'h31, 3'd1);
    @(posedge clk);
    #1 bus.in_valid = '0;
    check("bp_next_beat_ch", 32'(bus.out_ch), 32'd1);
    @(posedge clk);

    // Five-channel instance: out-of-range sel grants nothing, sel=4 works.
    bus5.sel      = 3'd6;
    bus5.in_valid = 5'h1F;
    #1 check("n5_sel6_ready", 32'(bus5.in_ready), 32'h0);
    @(posedge clk);
    #1 check("n5_sel6_valid", 32'(bus5.out_valid), 32'h0);
    bus5.sel = 3'd4;
    #1 check("n5_sel4_ready", 32'(bus5.in_ready), 32'h10);
    @(posedge clk);
    #1 bus5.in_valid = '0;
    check("n5_sel4_valid", 32'(bus5.out_valid), 32'h1);
    check("n5_sel4_ch",    32'(bus5.out_ch),    32'd4);
    check("n5_sel4_data",  32'(bus5.out_data),  32'h34);

    // Asynchronous reset mid-cycle while a beat is held; pointer (2) returns to 0.
    bus.mode      = MODE_MANUAL;
    bus.sel       = 3'd2;
    bus.out_ready = 1'b0;
    bus.in_valid  = '1;
    #1 check("rst_pre_ready", 32'(bus.in_ready), 32'h04);
    @(posedge clk);
    #1 check("rst_pre_valid", 32'(bus.out_valid), 32'h1);
    check("rst_pre_ch", 32'(bus.out_ch), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_valid",    32'(bus.out_valid), 32'h0);
    check("rst_async_ch",       32'(bus.out_ch),    32'h0);
    check("rst_async_data",     32'(bus.out_data),  32'h0);
    check("rst_async_in_ready", 32'(bus.in_ready),  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mode      = MODE_RR;
    bus.out_ready = 1'b1;
    #1 check("rst_ptr_zero", 32'(bus.in_ready), 32'h01);
    push(8'h30, 3'd0);
    @(posedge clk);
    #1 bus.in_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 check("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
